// File: rtl/mem_cmd_gen_pkg.sv
// rtl/mem_cmd_gen_pkg.sv - shared types, button indices and helpers for mem_cmd_gen
package mem_cmd_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } req_state_t;

    localparam int BTN_COMMIT = 0;
    localparam int BTN_INC    = 1;
    localparam int BTN_CUR    = 2;
    localparam int BTN_CLR    = 3;

    localparam logic [1:0] CURSOR_INIT = 2'd3;

    // Increment one nibble modulo 16; the carry never leaks into neighbours.
    function automatic logic [15:0] nibble_inc(input logic [15:0] d, input logic [1:0] sel);
        logic [15:0] r;
        r = d;
        r[{sel, 2'b00} +: 4] = d[{sel, 2'b00} +: 4] + 4'd1;
        return r;
    endfunction

endpackage

// File: rtl/mem_cmd_gen_if.sv
// rtl/mem_cmd_gen_if.sv - write request handshake bus between mem_cmd_gen and the memory stage
interface mem_cmd_gen_if;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        wr_done;
    logic        wr_err;

    modport master (
        output wr_req, wr_addr, wr_data, wr_done, wr_err,
        input  wr_ack
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, wr_done, wr_err,
        output wr_ack
    );
endinterface

// File: rtl/mem_cmd_gen_debounce.sv
// rtl/mem_cmd_gen_debounce.sv - two-flop sync, stable-count debounce and press pulse for one button
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    // The counter only runs while the synced input disagrees with the level,
    // so any glitch back to the current level restarts the stability window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            press  <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= ~level_q;
                cnt_q   <= '0;
                press   <= ~level_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_cmd_gen.sv
// rtl/mem_cmd_gen.sv - button-driven halfword editor issuing req/ack write commands with timeout
module mem_cmd_gen
    import mem_cmd_gen_pkg::*;
#(
    parameter int          DB_CYCLES   = 500000,
    parameter int          ACK_TIMEOUT = 1024,
    parameter logic [15:0] INIT_DATA   = 16'hABCD
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    btn_in,
    input  logic [7:0]    switch,
    mem_cmd_gen_if.master wr_bus,
    output logic [15:0]   edit_data,
    output logic [1:0]    cursor
);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    logic [3:0]  press;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic [15:0] edit_q;
    logic [1:0]  cur_q;

    req_state_t  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        req_q, req_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        err_q, err_d;

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_in[i]),
            .press (press[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_meta_q <= 8'h00;
            sw_sync_q <= 8'h00;
        end else begin
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Clear wins over increment; a cursor move in the same cycle lands after
    // the increment, so the increment still targets the old nibble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edit_q <= INIT_DATA;
            cur_q  <= CURSOR_INIT;
        end else begin
            if (press[BTN_CLR]) begin
                edit_q <= 16'h0000;
            end else if (press[BTN_INC]) begin
                edit_q <= nibble_inc(edit_q, cur_q);
            end
            if (press[BTN_CUR]) begin
                cur_q <= cur_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            req_q   <= 1'b0;
            addr_q  <= 8'h00;
            data_q  <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (press[BTN_COMMIT]) begin
                    addr_d  = sw_sync_q;
                    data_d  = edit_q;
                    req_d   = 1'b1;
                    err_d   = 1'b0;
                    timer_d = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack arriving on the final timeout cycle still counts.
                if (wr_bus.wr_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign wr_bus.wr_req  = req_q;
    assign wr_bus.wr_addr = addr_q;
    assign wr_bus.wr_data = data_q;
    assign wr_bus.wr_err  = err_q;
    assign wr_bus.wr_done = (state_q == ST_DONE);
    assign edit_data      = edit_q;
    assign cursor         = cur_q;
endmodule

// File: tb/tb_mem_cmd_gen.sv
// tb/tb_mem_cmd_gen.sv - directed table-driven bench for mem_cmd_gen
module tb_mem_cmd_gen;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  btn_in;
    logic [7:0]  switch;
    logic [15:0] edit_data;
    logic [1:0]  cursor;

    mem_cmd_gen_if bus ();

    mem_cmd_gen #(
        .DB_CYCLES   (4),
        .ACK_TIMEOUT (8),
        .INIT_DATA   (16'hABCD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .switch    (switch),
        .wr_bus    (bus),
        .edit_data (edit_data),
        .cursor    (cursor)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  btns;
        logic [15:0] exp_edit;
        logic [1:0]  exp_cur;
    } vec_t;

    vec_t vecs [17];

    int n_checks = 0;
    int n_fail   = 0;
    int rises    = 0;
    int base;
    logic req_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.wr_req && !req_prev) rises <= rises + 1;
        req_prev <= bus.wr_req;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press_mask(input logic [3:0] m);
        btn_in = m;
        tick(10);
        btn_in = 4'b0000;
        tick(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'b0010, 16'hBBCD, 2'd3};
        vecs[1]  = '{4'b0010, 16'hCBCD, 2'd3};
        vecs[2]  = '{4'b0010, 16'hDBCD, 2'd3};
        vecs[3]  = '{4'b0010, 16'hEBCD, 2'd3};
        vecs[4]  = '{4'b0010, 16'hFBCD, 2'd3};
        vecs[5]  = '{4'b0010, 16'h0BCD, 2'd3};
        vecs[6]  = '{4'b0100, 16'h0BCD, 2'd2};
        vecs[7]  = '{4'b0100, 16'h0BCD, 2'd1};
        vecs[8]  = '{4'b0100, 16'h0BCD, 2'd0};
        vecs[9]  = '{4'b0100, 16'h0BCD, 2'd3};
        vecs[10] = '{4'b1000, 16'h0000, 2'd3};
        vecs[11] = '{4'b0100, 16'h0000, 2'd2};
        vecs[12] = '{4'b0010, 16'h0100, 2'd2};
        vecs[13] = '{4'b0110, 16'h0200, 2'd1};
        vecs[14] = '{4'b1010, 16'h0000, 2'd1};
        vecs[15] = '{4'b0010, 16'h0010, 2'd1};
        vecs[16] = '{4'b0100, 16'h0010, 2'd0};

        rst_n      = 1'b0;
        btn_in     = 4'b0000;
        switch     = 8'h00;
        bus.wr_ack = 1'b0;
        tick(2);
        check("rst_req",    32'(bus.wr_req), 32'h0);
        check("rst_err",    32'(bus.wr_err), 32'h0);
        check("rst_edit",   32'(edit_data),  32'hABCD);
        check("rst_cursor", 32'(cursor),     32'h3);
        rst_n = 1'b1;
        tick(2);

        // Bounce: only one request may come out of a noisy commit
        switch = 8'h07;
        base   = rises;
        for (int i = 0; i < 10; i++) begin
            btn_in[0] = ~btn_in[0];
            tick(2);
        end
        check("bounce_no_early_req", 32'(rises - base), 32'h0);
        btn_in[0] = 1'b1;
        for (int k = 0; k < 20 && !bus.wr_req; k++) tick(1);
        check("bounce_req",  32'(bus.wr_req),  32'h1);
        check("bounce_addr", 32'(bus.wr_addr), 32'h07);
        check("bounce_data", 32'(bus.wr_data), 32'hABCD);
        tick(15);
        check("bounce_one_rise", 32'(rises - base), 32'h1);
        check("bounce_err",      32'(bus.wr_err),   32'h1);
        btn_in = 4'b0000;
        tick(12);

        for (int i = 0; i < 17; i++) begin
            press_mask(vecs[i].btns);
            check($sformatf("edit_v%0d", i),   32'(edit_data), 32'(vecs[i].exp_edit));
            check($sformatf("cursor_v%0d", i), 32'(cursor),    32'(vecs[i].exp_cur));
        end

        // Handshake with ack five cycles after the request rises
        switch    = 8'h3C;
        btn_in[0] = 1'b1;
        tick(6);
        check("hs_latency_low", 32'(bus.wr_req), 32'h0);
        tick(1);
        check("hs_req",  32'(bus.wr_req),  32'h1);
        check("hs_err",  32'(bus.wr_err),  32'h0);
        check("hs_addr", 32'(bus.wr_addr), 32'h3C);
        check("hs_data", 32'(bus.wr_data), 32'h0010);
        tick(4);
        check("hs_req_held", 32'(bus.wr_req), 32'h1);
        bus.wr_ack = 1'b1;
        tick(1);
        bus.wr_ack = 1'b0;
        check("hs_req_drop", 32'(bus.wr_req),  32'h0);
        check("hs_done",     32'(bus.wr_done), 32'h1);
        tick(1);
        check("hs_done_once", 32'(bus.wr_done), 32'h0);
        check("hs_err_clear", 32'(bus.wr_err),  32'h0);
        btn_in = 4'b0000;
        tick(12);

        // Timeout, with a second commit press landing on the last REQ cycle
        base      = rises;
        btn_in[0] = 1'b1;
        tick(4);
        btn_in[0] = 1'b0;
        tick(3);
        check("to_req", 32'(bus.wr_req), 32'h1);
        tick(1);
        btn_in[0] = 1'b1;
        tick(6);
        check("to_req_last",  32'(bus.wr_req), 32'h1);
        check("to_err_early", 32'(bus.wr_err), 32'h0);
        tick(1);
        check("to_req_drop", 32'(bus.wr_req), 32'h0);
        check("to_err",      32'(bus.wr_err), 32'h1);
        btn_in = 4'b0000;
        tick(12);
        check("to_single_req", 32'(rises - base), 32'h1);
        check("to_err_sticky", 32'(bus.wr_err),   32'h1);
        btn_in[0] = 1'b1;
        tick(7);
        check("to_recommit_req", 32'(bus.wr_req), 32'h1);
        check("to_recommit_err", 32'(bus.wr_err), 32'h0);
        tick(10);
        btn_in = 4'b0000;
        tick(12);

        // Reset in the middle of a request
        press_mask(4'b0010);
        btn_in[0] = 1'b1;
        tick(7);
        check("mid_req", 32'(bus.wr_req), 32'h1);
        rst_n  = 1'b0;
        btn_in = 4'b0000;
        tick(1);
        check("mid_rst_req",    32'(bus.wr_req), 32'h0);
        check("mid_rst_edit",   32'(edit_data),  32'hABCD);
        check("mid_rst_cursor", 32'(cursor),     32'h3);
        check("mid_rst_err",    32'(bus.wr_err), 32'h0);
        rst_n = 1'b1;
        tick(2);
        bus.wr_ack = 1'b1;
        tick(1);
        bus.wr_ack = 1'b0;
        check("mid_ack_no_done", 32'(bus.wr_done), 32'h0);
        tick(1);
        check("mid_ack_no_done2", 32'(bus.wr_done), 32'h0);
        check("mid_ack_no_req",   32'(bus.wr_req),  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
